wb_write_buffer: RTL and testbench

- Write-back buffer between the direct-mapped cache and main memory; it is transparent to both sides.
- Upstream port uses the cache↔main-memory line protocol (req/gnt, line-granular address). Downstream port drives main memory with the same protocol.
- Dirty-line evictions are absorbed in about 2 cycles and drained to memory in the background. Reads are forwarded from buffered entries, so no stale data is returned.

---
 rtl/wb_write_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_wb_write_buffer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_write_buffer.sv
// wb_write_buffer
//   Write-back buffer placed between a direct-mapped cache and main memory.
//   Dirty-line evictions from the cache are absorbed into a small circular
//   FIFO and drained to memory in the background. Reads that hit a buffered
//   line are answered from the buffer, so the cache never sees stale data.
//   Reads that miss bypass pending drains and go straight to memory.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   up_rd_req       line read request from cache
//   up_wr_req       line write (eviction) request from cache
//   up_addr         line address of the upstream request
//   up_wr_line      line to write (word i at bits [32i+31:32i])
//   up_gnt          one-cycle completion pulse to the cache
//   up_rd_line      read-response line, held until the next read response
//   mem_rd_req      read request to main memory
//   mem_wr_req      write request to main memory
//   mem_addr        memory line address (0 while no request is active)
//   mem_wr_line     line written to memory
//   mem_rd_line     line returned by memory, valid with mem_gnt
//   mem_gnt         memory completion pulse
//   count           number of occupied buffer entries
module wb_write_buffer #(
  parameter  int LINE_ADDR_LEN = 3,
  parameter  int ADDR_LEN      = 9,
  parameter  int DEPTH         = 4,
  localparam int LW            = 32 << LINE_ADDR_LEN,
  localparam int CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                up_rd_req,
  input  logic                up_wr_req,
  input  logic [ADDR_LEN-1:0] up_addr,
  input  logic [LW-1:0]       up_wr_line,
  output logic                up_gnt,
  output logic [LW-1:0]       up_rd_line,
  output logic                mem_rd_req,
  output logic                mem_wr_req,
  output logic [ADDR_LEN-1:0] mem_addr,
  output logic [LW-1:0]       mem_wr_line,
  input  logic [LW-1:0]       mem_rd_line,
  input  logic                mem_gnt,
  output logic [CNT_W-1:0]    count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_FETCH,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [ADDR_LEN-1:0] addr_q [DEPTH];
  logic [ADDR_LEN-1:0] addr_d [DEPTH];
  logic [LW-1:0]       line_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
  logic [LW-1:0]       mem_wr_line_q, mem_wr_line_d;
  logic [LW-1:0]       up_rd_line_q, up_rd_line_d;

  // Single write port into the line storage (push at tail or coalesce).
  logic                line_we;
  logic [PTR_W-1:0]    line_widx;

  logic [DEPTH-1:0]    match;
  logic                hit;
  logic [PTR_W-1:0]    hit_idx;
  logic                full;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = valid_q[gi] && (addr_q[gi] == up_addr);
  end

  // Writes to a buffered address always coalesce, so at most one valid
  // entry ever holds a given address; a plain priority pick is enough.
  always_comb begin
    hit     = |match;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) hit_idx = PTR_W'(i);
    end
  end

  assign full = (count_q == CNT_W'(DEPTH));

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    addr_d        = addr_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_line_d = mem_wr_line_q;
    up_rd_line_d  = up_rd_line_q;
    line_we       = 1'b0;
    line_widx     = tail_q;

    case (state_q)
      S_IDLE: begin
        if (up_rd_req) begin
          // Read wins over a simultaneous write.
          if (hit) begin
            up_rd_line_d = line_q[hit_idx];
            state_d      = S_RESP;
          end else begin
            mem_addr_d = up_addr;
            state_d    = S_FETCH;
          end
        end else if (up_wr_req && (hit || !full)) begin
          line_we = 1'b1;
          state_d = S_RESP;
          if (hit) begin
            line_widx = hit_idx;
          end else begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = up_addr;
            tail_d          = tail_q + 1'b1;
            count_d         = count_q + 1'b1;
          end
        end else if (count_q != '0) begin
          // Also reached by a write to a full buffer: freeing the head
          // slot is the only way that write can make progress.
          mem_addr_d    = addr_q[head_q];
          mem_wr_line_d = line_q[head_q];
          state_d       = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_gnt) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + 1'b1;
          count_d         = count_q - 1'b1;
          state_d         = S_IDLE;
        end
      end
      S_FETCH: begin
        if (mem_gnt) begin
          up_rd_line_d = mem_rd_line;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      mem_addr_q    <= '0;
      mem_wr_line_q <= '0;
      up_rd_line_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_line_q <= mem_wr_line_d;
      up_rd_line_q  <= up_rd_line_d;
      addr_q        <= addr_d;
    end
  end

  // Line payload needs no reset: an entry is only read while its valid bit
  // is set, and valid bits are cleared by reset.
  always_ff @(posedge clk) begin
    if (line_we) line_q[line_widx] <= up_wr_line;
  end

  // Request strobes come straight from the state register so an
  // asynchronous reset withdraws them in the same cycle.
  assign up_gnt      = (state_q == S_RESP);
  assign mem_wr_req  = (state_q == S_DRAIN);
  assign mem_rd_req  = (state_q == S_FETCH);
  assign mem_addr    = (mem_wr_req || mem_rd_req) ? mem_addr_q : '0;
  assign mem_wr_line = mem_wr_line_q;
  assign up_rd_line  = up_rd_line_q;
  assign count       = count_q;

endmodule

// File: tb/tb_wb_write_buffer.sv
// tb_wb_write_buffer
//   Directed bench for wb_write_buffer: write/drain, read hit from the
//   buffer, coalescing, write-when-full, read miss, read-over-write
//   priority and reset in the middle of a drain. Main memory is a small
//   stub with a fixed grant latency that can be stalled.
module tb_wb_write_buffer;

  localparam int LINE_ADDR_LEN = 3;
  localparam int ADDR_LEN      = 9;
  localparam int DEPTH         = 4;
  localparam int LW            = 256;
  localparam int CNT_W         = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic                up_rd_req;
  logic                up_wr_req;
  logic [ADDR_LEN-1:0] up_addr;
  logic [LW-1:0]       up_wr_line;
  logic                up_gnt;
  logic [LW-1:0]       up_rd_line;
  logic                mem_rd_req;
  logic                mem_wr_req;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [LW-1:0]       mem_wr_line;
  logic [LW-1:0]       mem_rd_line;
  logic                mem_gnt = 1'b0;
  logic [CNT_W-1:0]    count;

  wb_write_buffer #(
    .LINE_ADDR_LEN(LINE_ADDR_LEN),
    .ADDR_LEN     (ADDR_LEN),
    .DEPTH        (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .up_rd_req  (up_rd_req),
    .up_wr_req  (up_wr_req),
    .up_addr    (up_addr),
    .up_wr_line (up_wr_line),
    .up_gnt     (up_gnt),
    .up_rd_line (up_rd_line),
    .mem_rd_req (mem_rd_req),
    .mem_wr_req (mem_wr_req),
    .mem_addr   (mem_addr),
    .mem_wr_line(mem_wr_line),
    .mem_rd_line(mem_rd_line),
    .mem_gnt    (mem_gnt),
    .count      (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Memory stub: grants a pending request three cycles after it appears
  // unless stalled; logs every completed write.
  logic          mem_stall = 1'b1;
  int            mem_wait = 0;
  int            wr_cnt = 0;
  int            rd_cycles = 0;
  int            wr_cycles = 0;
  logic [8:0]    wr_last_addr = '0;
  logic [LW-1:0] wr_last_line = '0;

  always @(posedge clk) begin
    if ((mem_wr_req || mem_rd_req) && !mem_gnt && !mem_stall) begin
      if (mem_wait >= 2) begin
        mem_gnt  <= 1'b1;
        mem_wait <= 0;
      end else begin
        mem_wait <= mem_wait + 1;
      end
    end else begin
      mem_gnt  <= 1'b0;
      mem_wait <= 0;
    end
  end

  always @(posedge clk) begin
    if (mem_gnt && mem_wr_req) begin
      wr_cnt       <= wr_cnt + 1;
      wr_last_addr <= mem_addr;
      wr_last_line <= mem_wr_line;
    end
    if (mem_rd_req) rd_cycles <= rd_cycles + 1;
    if (mem_wr_req) wr_cycles <= wr_cycles + 1;
  end

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + 32'(i);
    return l;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges from the request cycle (0) until up_gnt; -1 on timeout.
  task automatic wait_gnt(input int limit, output int lat);
    lat = -1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (up_gnt) begin
        lat = n;
        break;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic req_write(input logic [8:0] a, input logic [LW-1:0] l,
                           output int lat, output logic [CNT_W-1:0] cnt);
    up_wr_req  = 1'b1;
    up_addr    = a;
    up_wr_line = l;
    wait_gnt(40, lat);
    cnt = count;
    @(posedge clk); #1;
    up_wr_req = 1'b0;
    $display("write addr=0x%03h gnt_latency=%0d count=%0d", a, lat, cnt);
  endtask

  task automatic wait_empty(input int limit);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (count == '0 && !mem_wr_req) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [LW-1:0]    line_l1, line_l2, line_a, line_b, line_f5, line_cafe;
  int               lat;
  logic [CNT_W-1:0] cnt;
  int               w0, rd0, wc0;
  logic             gnt_seen;

  initial begin
    line_l1   = mk_line(32'h0000_1000);
    line_l2   = mk_line(32'h0000_2000);
    line_a    = mk_line(32'h0000_A000);
    line_b    = mk_line(32'h0000_B000);
    line_f5   = mk_line(32'h0000_3500);
    line_cafe = mk_line(32'hCAFE_0000);
    mem_rd_line = line_cafe;
    rst        = 1'b1;
    up_rd_req  = 1'b0;
    up_wr_req  = 1'b0;
    up_addr    = '0;
    up_wr_line = '0;
    mem_stall  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_up_gnt", 32'(up_gnt), 0);
    check_val("rst_mem_wr_req", 32'(mem_wr_req), 0);
    check_val("rst_mem_rd_req", 32'(mem_rd_req), 0);
    check_val("rst_mem_addr", 32'(mem_addr), 0);
    check_val("rst_count", 32'(count), 0);
    check_line("rst_up_rd_line", up_rd_line, '0);
    check_line("rst_mem_wr_line", mem_wr_line, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single write then background drain
    req_write(9'h005, line_l1, lat, cnt);
    check_val("t1_wr_latency", 32'(lat), 1);
    check_val("t1_count_after_wr", 32'(cnt), 1);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_wr_req) break;
    end
    check_val("t1_mem_wr_req", 32'(mem_wr_req), 1);
    check_val("t1_mem_addr", 32'(mem_addr), 32'h005);
    check_line("t1_mem_wr_line", mem_wr_line, line_l1);
    wait_empty(40);
    check_val("t1_count_drained", 32'(count), 0);
    check_val("t1_wr_cnt", 32'(wr_cnt), 1);
    check_val("t1_wr_addr", 32'(wr_last_addr), 32'h005);
    check_line("t1_wr_line", wr_last_line, line_l1);
    $display("drain addr=0x005 writes=%0d", wr_cnt);

    // 2: read hit served from the buffer while memory is stalled
    mem_stall = 1'b1;
    rd0 = rd_cycles;
    req_write(9'h012, line_l2, lat, cnt);
    check_val("t2_wr_latency", 32'(lat), 1);
    up_rd_req = 1'b1;
    up_addr   = 9'h012;
    wait_gnt(20, lat);
    check_val("t2_rd_hit_latency", 32'(lat), 1);
    check_line("t2_rd_hit_line", up_rd_line, line_l2);
    @(posedge clk); #1;
    up_rd_req = 1'b0;
    $display("read addr=0x012 hit gnt_latency=%0d", lat);
    mem_stall = 1'b0;
    wait_empty(60);
    check_val("t2_no_mem_rd", 32'(rd_cycles), 32'(rd0));
    check_val("t2_wr_addr", 32'(wr_last_addr), 32'h012);
    check_line("t2_wr_line", wr_last_line, line_l2);

    // 3: back-to-back writes to one address coalesce
    mem_stall = 1'b1;
    w0 = wr_cnt;
    req_write(9'h020, line_a, lat, cnt);
    req_write(9'h020, line_b, lat, cnt);
    check_val("t3_coalesce_latency", 32'(lat), 1);
    check_val("t3_coalesce_count", 32'(cnt), 1);
    mem_stall = 1'b0;
    wait_empty(60);
    repeat (5) @(negedge clk);
    check_val("t3_single_drain", 32'(wr_cnt), 32'(w0 + 1));
    check_val("t3_wr_addr", 32'(wr_last_addr), 32'h020);
    check_line("t3_wr_line", wr_last_line, line_b);
    @(posedge clk); #1;

    // 4: fill the buffer, then a write to a full buffer waits for a drain
    mem_stall = 1'b1;
    w0 = wr_cnt;
    for (int a = 1; a <= 4; a++) begin
      req_write(9'(a), mk_line(32'h3000 + 32'(a) * 32'h100), lat, cnt);
      check_val("t4_fill_latency", 32'(lat), 1);
      check_val("t4_fill_count", 32'(cnt), 32'(a));
    end
    up_wr_req  = 1'b1;
    up_addr    = 9'h005;
    up_wr_line = line_f5;
    gnt_seen   = 1'b0;
    repeat (8) begin
      @(negedge clk);
      gnt_seen = gnt_seen | up_gnt;
    end
    check_val("t4_full_no_gnt", 32'(gnt_seen), 0);
    check_val("t4_full_count", 32'(count), 4);
    mem_stall = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_gnt && mem_wr_req) break;
    end
    check_val("t4_head_drain_gnt", 32'(mem_gnt), 1);
    check_val("t4_head_drain_addr", 32'(mem_addr), 32'h001);
    @(negedge clk);
    check_val("t4_gnt_plus1", 32'(up_gnt), 0);
    @(negedge clk);
    check_val("t4_gnt_plus2", 32'(up_gnt), 1);
    check_val("t4_count_after", 32'(count), 4);
    @(posedge clk); #1;
    up_wr_req = 1'b0;
    $display("write addr=0x005 full buffer accepted after drain");
    wait_empty(200);
    check_val("t4_total_drains", 32'(wr_cnt), 32'(w0 + 5));
    check_val("t4_last_addr", 32'(wr_last_addr), 32'h005);
    check_line("t4_last_line", wr_last_line, line_f5);

    // 5: read miss fetched from memory, response held afterwards
    up_rd_req = 1'b1;
    up_addr   = 9'h030;
    @(negedge clk);
    @(negedge clk);
    check_val("t5_mem_rd_req", 32'(mem_rd_req), 1);
    check_val("t5_mem_rd_addr", 32'(mem_addr), 32'h030);
    check_val("t5_no_mem_wr", 32'(mem_wr_req), 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_gnt && mem_rd_req) break;
    end
    @(negedge clk);
    check_val("t5_miss_gnt", 32'(up_gnt), 1);
    check_line("t5_miss_line", up_rd_line, line_cafe);
    @(posedge clk); #1;
    up_rd_req = 1'b0;
    $display("read addr=0x030 miss line=0x%0h", up_rd_line[31:0]);
    repeat (5) @(negedge clk);
    check_line("t5_line_held", up_rd_line, line_cafe);
    check_val("t5_idle_mem_addr", 32'(mem_addr), 0);

    // Simultaneous read and write: the read wins, nothing is buffered
    @(posedge clk); #1;
    up_rd_req  = 1'b1;
    up_wr_req  = 1'b1;
    up_addr    = 9'h040;
    up_wr_line = line_a;
    wait_gnt(30, lat);
    check_val("t5b_rd_wins_gnt", 32'(up_gnt), 1);
    check_val("t5b_rd_wins_count", 32'(count), 0);
    @(posedge clk); #1;
    up_rd_req = 1'b0;
    up_wr_req = 1'b0;
    $display("read+write addr=0x040 gnt_latency=%0d count=%0d", lat, count);

    // 6: reset in the middle of a drain
    mem_stall = 1'b1;
    w0 = wr_cnt;
    req_write(9'h101, line_a, lat, cnt);
    req_write(9'h102, line_b, lat, cnt);
    req_write(9'h103, line_l1, lat, cnt);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_wr_req) break;
    end
    check_val("t6_in_drain", 32'(mem_wr_req), 1);
    check_val("t6_count_before", 32'(count), 3);
    rst = 1'b1;
    #1;
    check_val("t6_rst_mem_wr_req", 32'(mem_wr_req), 0);
    check_val("t6_rst_up_gnt", 32'(up_gnt), 0);
    check_val("t6_rst_count", 32'(count), 0);
    check_val("t6_rst_mem_addr", 32'(mem_addr), 0);
    mem_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wc0 = wr_cycles;
    repeat (10) @(negedge clk);
    check_val("t6_no_drain_after", 32'(wr_cycles), 32'(wc0));
    check_val("t6_no_mem_write", 32'(wr_cnt), 32'(w0));
    check_val("t6_count_after", 32'(count), 0);
    $display("reset during drain count=%0d", count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
